// File: rtl/two_level_tag_lookup.sv
// two_level_tag_lookup
//   Tag store and lookup controller for a two-level direct-mapped cache.
//   A request's split fields are latched in IDLE. L1 is checked first; on an
//   L1 miss L2 is checked. Both tag stores are filled as needed. The outcome
//   is reported on hit1/hit2/miss with a one-cycle done pulse, and three
//   saturating event counters are kept.
//
// Ports
//   clk      clock, all state updates on posedge
//   rst      asynchronous active-high reset
//   strobe   request valid (sampled only in IDLE)
//   tag1     L1 tag,   set1  L1 set index
//   tag2     L2 tag,   set2  L2 set index
//   busy     high whenever the controller is not idle
//   done     one-cycle completion pulse
//   hit1     last request hit L1
//   hit2     last request missed L1 and hit L2
//   miss     last request missed both levels
//   l1_hits, l2_hits, misses   saturating 16-bit event counters
module two_level_tag_lookup #(
   parameter int TAGWID1 = 3,
   parameter int SETWID1 = 9,
   parameter int TAGWID2 = 2,
   parameter int SETWID2 = 10,
   parameter int SETNUM1 = 512,
   parameter int SETNUM2 = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               strobe,
   input  logic [TAGWID1-1:0] tag1,
   input  logic [SETWID1-1:0] set1,
   input  logic [TAGWID2-1:0] tag2,
   input  logic [SETWID2-1:0] set2,
   output logic               busy,
   output logic               done,
   output logic               hit1,
   output logic               hit2,
   output logic               miss,
   output logic [15:0]        l1_hits,
   output logic [15:0]        l2_hits,
   output logic [15:0]        misses
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_L1_CMP = 2'd1;
   localparam logic [1:0] S_L2_CMP = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   logic [1:0]         state;
   logic [TAGWID1-1:0] tag1_reg;
   logic [SETWID1-1:0] set1_reg;
   logic [TAGWID2-1:0] tag2_reg;
   logic [SETWID2-1:0] set2_reg;

   // Tag arrays map onto block RAM; valid bits stay in flops so that reset
   // can clear them all at once.
   logic [TAGWID1-1:0] tagmem1 [SETNUM1];
   logic [TAGWID2-1:0] tagmem2 [SETNUM2];
   logic [SETNUM1-1:0] valid1;
   logic [SETNUM2-1:0] valid2;

   logic [TAGWID1-1:0] rd_tag1;
   logic [TAGWID2-1:0] rd_tag2;

   logic accept;
   logic l1_hit;
   logic l2_hit;
   logic l1_wr;
   logic l2_wr;

   assign accept = (state == S_IDLE) && strobe;
   assign l1_hit = valid1[set1_reg] && (rd_tag1 == tag1_reg);
   assign l2_hit = valid2[set2_reg] && (rd_tag2 == tag2_reg);
   // L1 is filled on every L1 miss; L2 only when it missed as well.
   assign l1_wr  = (state == S_L2_CMP);
   assign l2_wr  = (state == S_L2_CMP) && !l2_hit;
   assign busy   = (state != S_IDLE);

   // L1 tag RAM: read is issued straight from the input fields at the
   // accepting edge so the data is ready in L1_CMP. Any fill from the previous
   // request landed at least one edge earlier, so the read sees it.
   always_ff @(posedge clk) begin
      if (l1_wr)
         tagmem1[set1_reg] <= tag1_reg;
      if (accept)
         rd_tag1 <= tagmem1[set1];
   end

   // L2 tag RAM: read during L1_CMP, result used in L2_CMP.
   always_ff @(posedge clk) begin
      if (l2_wr)
         tagmem2[set2_reg] <= tag2_reg;
      if (state == S_L1_CMP)
         rd_tag2 <= tagmem2[set2_reg];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         tag1_reg <= '0;
         set1_reg <= '0;
         tag2_reg <= '0;
         set2_reg <= '0;
         valid1   <= '0;
         valid2   <= '0;
         done     <= 1'b0;
         hit1     <= 1'b0;
         hit2     <= 1'b0;
         miss     <= 1'b0;
         l1_hits  <= 16'd0;
         l2_hits  <= 16'd0;
         misses   <= 16'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (strobe) begin
                  tag1_reg <= tag1;
                  set1_reg <= set1;
                  tag2_reg <= tag2;
                  set2_reg <= set2;
                  hit1     <= 1'b0;
                  hit2     <= 1'b0;
                  miss     <= 1'b0;
                  state    <= S_L1_CMP;
               end
            end
            S_L1_CMP: begin
               if (l1_hit) begin
                  hit1  <= 1'b1;
                  done  <= 1'b1;
                  if (l1_hits != 16'hFFFF)
                     l1_hits <= l1_hits + 16'd1;
                  state <= S_RESP;
               end else begin
                  state <= S_L2_CMP;
               end
            end
            S_L2_CMP: begin
               valid1[set1_reg] <= 1'b1;
               done             <= 1'b1;
               if (l2_hit) begin
                  hit2 <= 1'b1;
                  if (l2_hits != 16'hFFFF)
                     l2_hits <= l2_hits + 16'd1;
               end else begin
                  valid2[set2_reg] <= 1'b1;
                  miss             <= 1'b1;
                  if (misses != 16'hFFFF)
                     misses <= misses + 16'd1;
               end
               state <= S_RESP;
            end
            default: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
